// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and sizing helpers for the restoring divider.
// Revision : 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_n_default = 4;
    localparam int c_cnt_w     = $clog2(c_n_default);

    // Iteration counter width for an N-bit divider; it holds N-1 at most.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : ripple_borrow_subtractor
// Purpose  : W-bit a - b - bin built from a chain of full subtractors.
// Revision : 1.0
// ============================================================================
module ripple_borrow_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] w_borrow;

    assign w_borrow[0] = bin;

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            assign diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
            assign w_borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
        end
    endgenerate

    assign bout = w_borrow[W];

endmodule
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : restoring_divider
// Purpose  : Multi-cycle restoring divider, one trial subtraction per clock.
//            Define DIV_SIGNED_EN for two's-complement operands.
// Revision : 1.0
// ============================================================================
module restoring_divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int c_cw = cnt_width(N);

    state_t          r_state;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_div;
    logic [c_cw-1:0] r_cnt;
    logic            r_fin;
    logic            r_fin_dbz;

    logic [N:0]      w_rsh;
    logic [N:0]      w_diff;
    logic            w_bout;
    logic [N-1:0]    w_a_mag;
    logic [N-1:0]    w_b_mag;
    logic [N-1:0]    w_q_res;
    logic [N-1:0]    w_r_res;
    logic            w_unused_msb;

    // The working remainder never exceeds the divisor, so its top bit is always zero.
    assign w_unused_msb = r_rem[N];
    assign w_rsh        = {r_rem[N-1:0], r_q[N-1]};

    ripple_borrow_subtractor #(
        .W (N + 1)
    ) u_sub (
        .a    (w_rsh),
        .b    ({1'b0, r_div}),
        .bin  (1'b0),
        .diff (w_diff),
        .bout (w_bout)
    );

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_mag = dividend[N-1] ? -dividend : dividend;
    assign w_b_mag = divisor[N-1]  ? -divisor  : divisor;
    assign w_q_res = r_neg_q ? -r_q : r_q;
    assign w_r_res = r_neg_r ? -r_rem[N-1:0] : r_rem[N-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && start && divisor != '0) begin
            r_neg_q <= dividend[N-1] ^ divisor[N-1];
            r_neg_r <= dividend[N-1];
        end
    end
`else
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
    assign w_q_res = r_q;
    assign w_r_res = r_rem[N-1:0];
`endif

    // Results are registered one edge after the final iteration, so the
    // datapath is already free to accept a new operation in the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_fin_dbz   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done  <= r_fin;
            r_fin <= 1'b0;
            if (r_fin) begin
                div_by_zero <= r_fin_dbz;
                if (r_fin_dbz) begin
                    quotient  <= '1;
                    remainder <= r_q;
                end else begin
                    quotient  <= w_q_res;
                    remainder <= w_r_res;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_q       <= dividend;
                            r_fin     <= 1'b1;
                            r_fin_dbz <= 1'b1;
                        end else begin
                            r_rem     <= '0;
                            r_q       <= w_a_mag;
                            r_div     <= w_b_mag;
                            r_cnt     <= c_cw'(N - 1);
                            r_fin_dbz <= 1'b0;
                            r_state   <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_q   <= {r_q[N-2:0], ~w_bout};
                    r_rem <= w_bout ? w_rsh : w_diff;
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        r_fin   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_restoring_divider
// Purpose  : Directed and randomized checks of restoring_divider against a
//            cycle-level arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_restoring_divider;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_err    = 0;

    restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: quotient, remainder and divide-by-zero flag.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
`endif
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            z = 1'b0;
`ifdef DIV_SIGNED_EN
            if (sa == -(1 << (N - 1)) && sb == -1) begin
                q = a;
                r = '0;
            end else begin
                q = N'(sa / sb);
                r = N'(sa % sb);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Cycle model: an accepted operation finishes N+1 edges later (1 for a
    // zero divisor) and keeps the unit busy for the first N of them.
    int           busy_left = 0;
    int           done_left = 0;
    bit           m_free;
    logic [N-1:0] p_q, p_r;
    logic         p_z;
    logic         m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;
    logic [N-1:0] m_q = '0, m_r = '0;
    bit           model_live = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            busy_left  = 0;
            done_left  = 0;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_q        = '0;
            m_r        = '0;
            m_z        = 1'b0;
            model_live = 1'b1;
        end else begin
            m_free = (busy_left == 0);
            m_done = 1'b0;
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = p_z;
                end
            end
            if (busy_left > 0) busy_left--;
            if (m_free && start) begin
                ref_div(dividend, divisor, p_q, p_r, p_z);
                if (p_z) begin
                    done_left = 1;
                end else begin
                    busy_left = N;
                    done_left = N + 1;
                end
            end
            m_busy = (busy_left > 0);
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_by_zero", div_by_zero, m_z);
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic ez, input int elat);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
        chk("op_latency", lat, elat);
        chk("op_quotient", quotient, eq);
        chk("op_remainder", remainder, er);
        chk("op_dbz", div_by_zero, ez);
    endtask

    logic [N-1:0] tq, tr;
    logic         tz;
    int           first_e, second_e;
    logic [N-1:0] q1, r1, q2, r2;
    bit           saw_done;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Hand-computed anchors for the reference function.
`ifdef DIV_SIGNED_EN
        ref_div(4'd9, 4'd2, tq, tr, tz);   // -7 / 2
        chk("ref_m7_2_q", tq, 4'b1101);
        chk("ref_m7_2_r", tr, 4'b1111);
        ref_div(4'd8, 4'd15, tq, tr, tz);  // -8 / -1
        chk("ref_m8_m1_q", tq, 4'b1000);
        chk("ref_m8_m1_r", tr, 4'b0000);
`else
        ref_div(4'd13, 4'd3, tq, tr, tz);
        chk("ref_13_3_q", tq, 4'd4);
        chk("ref_13_3_r", tr, 4'd1);
        ref_div(4'd7, 4'd0, tq, tr, tz);
        chk("ref_7_0_q", tq, 4'd15);
        chk("ref_7_0_z", tz, 1'b1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef DIV_SIGNED_EN
        run_op(4'd9,  4'd2,  4'b1101, 4'b1111, 1'b0, 5);
        run_op(4'd8,  4'd15, 4'b1000, 4'b0000, 1'b0, 5);
        run_op(4'd7,  4'd0,  4'd15,   4'd7,    1'b1, 1);
        run_op(4'd7,  4'd14, 4'b1101, 4'b0001, 1'b0, 5);
`else
        run_op(4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5);
        run_op(4'd7,  4'd0,  4'd15, 4'd7, 1'b1, 1);
        run_op(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5);
        run_op(4'd2,  4'd9,  4'd0,  4'd2, 1'b0, 5);
        run_op(4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5);
`endif

        // Back-to-back with start held; operand changes mid-RUN are ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        first_e  = -1;
        second_e = -1;
        for (int e = 0; e <= 11; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin dividend = 4'd5;  divisor = 4'd1; end
            if (e == 3) begin dividend = 4'd14; divisor = 4'd4; end
            if (e == 5) start = 1'b0;
            if (done) begin
                if (first_e < 0) begin
                    first_e = e; q1 = quotient; r1 = remainder;
                end else if (second_e < 0) begin
                    second_e = e; q2 = quotient; r2 = remainder;
                end
            end
        end
        chk("b2b_first_edge", first_e, 5);
        chk("b2b_spacing", second_e - first_e, 5);
`ifdef DIV_SIGNED_EN
        chk("b2b_q1", q1, 4'b1101);
        chk("b2b_r1", r1, 4'b1111);
        chk("b2b_q2", q2, 4'b0000);
        chk("b2b_r2", r2, 4'b1110);
`else
        chk("b2b_q1", q1, 4'd4);
        chk("b2b_r1", r1, 4'd1);
        chk("b2b_q2", q2, 4'd3);
        chk("b2b_r2", r2, 4'd2);
`endif

        // Reset sampled at the end of the third RUN cycle.
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_dbz", div_by_zero, 1'b0);
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst_no_done", saw_done, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op(4'd10, 4'd3, 4'b1110, 4'd0, 1'b0, 5);
`else
        run_op(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 5);
`endif

        // Randomized traffic; the every-cycle compare against the model checks it.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 2) != 0);
            dividend = N'($urandom);
            divisor  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Multi-cycle unsigned integer divider with a start/busy/done handshake. It is the inverse-direction counterpart to the ripple adder family: it performs one trial subtraction per clock through a ripple-borrow subtractor. It sits beside the adders in the combinational/arithmetic library for datapaths that can tolerate N+1 cycle latency in exchange for small area.

Parameters:
N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  N  numerator; latched in the cycle start is accepted
divisor  input  N  denominator; latched in the cycle start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; results are valid from this cycle on
quotient  output  N  registered result
remainder  output  N  registered result
div_by_zero  output  1  registered flag, valid with done

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0. Reset wins over every other event, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, divisor!=0: latch operands; working remainder R (N+1 bits)=0; working quotient Q=dividend; counter=N-1; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, divisor==0: stay in IDLE. On the next edge: quotient=all ones, remainder=dividend, div_by_zero=1, done=1 for one cycle. Latency is 1 cycle.
- RUN, each cycle:
  - shift {R,Q} left by 1;
  - compute D = R_shifted - {0,divisor} in the (N+1)-bit ripple-borrow subtractor;
  - if borrow_out=0: R=D and Q[0]=1; else R=R_shifted and Q[0]=0.
- RUN exit: when counter==0 after the update, register quotient=Q and remainder=R[N-1:0], set div_by_zero=0, pulse done=1, set busy=0, and return to IDLE. Otherwise decrement the counter.
- Latency: done rises exactly N+1 clock edges after the edge that samples start (N=4: 5 edges).
- start while busy=1 is ignored; operands are not re-latched.
- start in the same cycle as done is accepted (back-to-back). Results stay on the outputs until the next completion overwrites them.
- Result outputs change only on completion or reset, never mid-RUN.
- Invariants: dividend == quotient*divisor + remainder; remainder < divisor.

Optional Feature:
DIV_SIGNED_EN
- Defined: operands are two's complement.
  - The magnitudes are divided; the quotient is negated if the operand signs differ, truncating toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative / -1 yields quotient=most-negative (wrap) and remainder=0.
  - Divide by zero yields quotient=all ones and remainder=dividend.
  - Latency is unchanged: negation happens at latch and at result register.
- Undefined: pure unsigned behaviour as above; no sign logic is synthesised.

Decomposition:
- Package div_pkg: state typedef (IDLE, RUN), and a localparam for counter width, clog2(N).
- Sub-module ripple_borrow_subtractor #(W): full-subtractor chain built with generate. Ports: a, b, bin, diff, bout. Instantiated with W=N+1.

Test Plan:
- N=4, 13/3: start at edge 0 -> done at edge 5, quotient=4, remainder=1, div_by_zero=0; busy high on edges 1-4.
- 7/0 -> done after 1 edge, quotient=15, remainder=7, div_by_zero=1, busy never high.
- 15/1 -> quotient=15, remainder=0. 2/9 -> quotient=0, remainder=2. 0/5 -> quotient=0, remainder=0.
- start=1 held throughout: 9/2 then 14/4 back-to-back -> done pulses 5 edges apart; results 4/1, then 3/2. A start with changed operands mid-RUN has no effect.
- rst asserted during the third RUN cycle -> next edge: all outputs 0, busy=0, no done; a fresh 10/3 then yields 3/1.
- DIV_SIGNED_EN:
  - -7/2 -> quotient=4'b1101, remainder=4'b1111.
  - -8/-1 -> quotient=4'b1000, remainder=0.
  - Exhaustive random sweep checks the signed invariant.
